led_sequencer: RTL and testbench
================================

// Module: led_sequencer
// PURPOSE
//  Parametrised front-panel LED driver, successor to the fixed 8-LED power-on sweep.
//  - Runs a fill-then-drain animation after reset, or on request; can loop it.
//  - Otherwise shows a host-written pattern, dimmed by PWM brightness.
//  - Sits between the system clock domain and the board LED pins.
// PARAMETERS
//  N_LEDS       8        number of LEDs driven (>=2)
//  STEP_CYCLES  500_000  clocks per animation step (>=1); 50 ms at 10 MHz
//  BRIGHT_BITS  4        width of the brightness input and PWM counter (>=1)
// PORTS
//  clock        in   1            system clock, all logic on rising edge
//  reset        in   1            asynchronous, active-high reset
//  replay       in   1            1-cycle pulse: (re)start the animation
//  loop         in   1            1 = repeat the animation forever
//  pattern      in   N_LEDS       pattern shown in SHOW state
//  pattern_we   in   1            latch pattern into pattern_q
//  brightness   in   BRIGHT_BITS  SHOW duty; all-ones = fully on, 0 = off
//  leds         out  N_LEDS       registered LED drive, bit N_LEDS-1 = leftmost
//  busy         out  1            1 while in FILL or DRAIN
// BEHAVIOUR
//  Reset values: leds=0, busy=1, state=FILL, step_cnt=0, pwm_cnt=0, pattern_q=0.
//    The animation starts on reset release.
//  Prescaler: step_cnt counts 0..STEP_CYCLES-1 in FILL/DRAIN.
//    tick = (step_cnt==STEP_CYCLES-1); step_cnt wraps to 0 on tick.
//    step_cnt width = max(1, $clog2(STEP_CYCLES)).
//  FILL: on tick, leds <= {1'b1, leds[N-1:1]}.
//    When leds is all ones at a tick: go to DRAIN and apply the first drain shift
//    on that same tick.
//  DRAIN: on tick, leds <= {1'b0, leds[N-1:1]}.
//    When leds==1 at a tick: leds <= 0; next state is FILL if loop==1, else SHOW.
//    loop is sampled only on that tick.
//  One animation = 2*N_LEDS ticks.
//    The first lit LED appears STEP_CYCLES clocks after reset release or replay.
//  SHOW: busy=0; leds <= pattern_q & {N{pwm_on}} (1-clock latency).
//    pwm_cnt is a free-running BRIGHT_BITS counter.
//    pwm_on = (brightness=='1) | (pwm_cnt < brightness).
//    Within SHOW, a pattern_we or brightness change is visible one clock later.
//  FILL/DRAIN drive the LEDs at full brightness; brightness is ignored.
//  replay (any state): next clock state=FILL, leds=0, step_cnt=0, busy=1.
//    A replay during an animation restarts it from empty.
//  pattern_we (any state): pattern_q <= pattern next clock.
//    A write during animation is held and shown on entry to SHOW.
//  replay and pattern_we in the same cycle: both take effect.
//  loop=1 with no replay: animation repeats forever, busy stays 1.
//    Clearing loop ends it at the next drain completion.
//  Asynchronous reset mid-animation: outputs go to reset values immediately;
//    the animation restarts on release.
//  No X on any output after reset.
// STRUCTURE
//  Package led_seq_pkg: state enum {FILL, DRAIN, SHOW} and default-parameter constants.
//  Sub-module led_pwm: pwm_cnt + compare.
//    Params BRIGHT_BITS; ports clock, reset, brightness -> pwm_on.
//  Remainder (prescaler, FSM, shift register, pattern_q) lives in led_sequencer.
// TESTING (N_LEDS=4, STEP_CYCLES=3, BRIGHT_BITS=2 unless noted)
//  1 Reset release, loop=0 -> leds 1000 @clk3, 1100 @6, 1110 @9, 1111 @12, 0111 @15,
//    0011 @18, 0001 @21, 0000 @24; busy falls @24.
//  2 pattern_we with pattern=1010 at clk5, brightness=3 -> pattern held; leds=1010
//    from clk25 onward, steady.
//  3 SHOW, pattern=1111, brightness=1 -> leds=1111 exactly 1 of every 4 clocks;
//    brightness=0 -> leds stay 0000.
//  4 replay at clk10 (leds=1110) -> clk11 leds=0000, busy=1; 1000 @clk14;
//    animation completes @clk35.
//  5 loop=1 -> after 0001 the next tick gives 0000, then 1000 three clocks later;
//    busy never falls; loop cleared mid-run -> SHOW after that drain.
//  6 reset asserted asynchronously mid-DRAIN (between edges) -> leds=0, busy=1
//    before the next edge; scenario 1 timing repeats from release.
//    Also run N_LEDS=8, STEP_CYCLES=1: 16 consecutive shifts.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared types and default constants for the front-panel LED sequencer.
package led_seq_pkg;

  // Animation phases plus the steady host-pattern display.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    SHOW  = 2'd2
  } seq_state_t;

  localparam int DEF_N_LEDS      = 8;
  localparam int DEF_STEP_CYCLES = 500_000;
  localparam int DEF_BRIGHT_BITS = 4;

  // Prescaler width; a single-cycle step still needs one bit of counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and duty compare for the SHOW brightness.
module led_pwm
  import led_seq_pkg::*;
#(
  parameter int BRIGHT_BITS = DEF_BRIGHT_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic                   pwm_on
);

  logic [BRIGHT_BITS-1:0] pwm_cnt_reg;

  // Counter runs continuously, independent of the sequencer state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  // All-ones brightness must be solidly on, so it bypasses the compare.
  assign pwm_on = (&brightness) | (pwm_cnt_reg < brightness);

endmodule

// File: rtl/led_sequencer.sv
// Front-panel LED driver: fill/drain power-on animation, then a host pattern
// dimmed by PWM. Animation restarts on reset release or a replay pulse.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS      = DEF_N_LEDS,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int BRIGHT_BITS = DEF_BRIGHT_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   replay,
  input  logic                   loop,
  input  logic [N_LEDS-1:0]      pattern,
  input  logic                   pattern_we,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]      leds,
  output logic                   busy
);

  localparam int                CW        = cnt_width(STEP_CYCLES);
  localparam logic [CW-1:0]     STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [N_LEDS-1:0] LAST_LIT  = N_LEDS'(1);

  seq_state_t        state_reg, state_next;
  logic [N_LEDS-1:0] leds_reg, leds_next;
  logic [N_LEDS-1:0] pattern_q_reg, pattern_q_next;
  logic [CW-1:0]     step_cnt_reg, step_cnt_next;
  logic              tick;
  logic              pwm_on;

  led_pwm #(
    .BRIGHT_BITS(BRIGHT_BITS)
  ) u_pwm (
    .clock      (clock),
    .reset      (reset),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

  assign tick = (step_cnt_reg == STEP_LAST);

  // State, LED shift register, prescaler and held pattern.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= FILL;
      leds_reg      <= '0;
      step_cnt_reg  <= '0;
      pattern_q_reg <= '0;
    end else begin
      state_reg     <= state_next;
      leds_reg      <= leds_next;
      step_cnt_reg  <= step_cnt_next;
      pattern_q_reg <= pattern_q_next;
    end
  end

  // Next-state: replay overrides everything except the pattern write.
  always_comb begin
    state_next     = state_reg;
    leds_next      = leds_reg;
    step_cnt_next  = step_cnt_reg;
    pattern_q_next = pattern_we ? pattern : pattern_q_reg;

    if (replay) begin
      state_next    = FILL;
      leds_next     = '0;
      step_cnt_next = '0;
    end else begin
      case (state_reg)
        FILL: begin
          step_cnt_next = tick ? '0 : step_cnt_reg + 1'b1;
          if (tick) begin
            if (&leds_reg) begin
              // Full bar: the first drain shift happens on this same tick.
              state_next = DRAIN;
              leds_next  = {1'b0, leds_reg[N_LEDS-1:1]};
            end else begin
              leds_next = {1'b1, leds_reg[N_LEDS-1:1]};
            end
          end
        end
        DRAIN: begin
          step_cnt_next = tick ? '0 : step_cnt_reg + 1'b1;
          if (tick) begin
            if (leds_reg == LAST_LIT) begin
              leds_next  = '0;
              state_next = loop ? FILL : SHOW;
            end else begin
              leds_next = {1'b0, leds_reg[N_LEDS-1:1]};
            end
          end
        end
        SHOW: begin
          step_cnt_next = '0;
          leds_next     = pattern_q_reg & {N_LEDS{pwm_on}};
        end
        default: begin
          state_next    = FILL;
          leds_next     = '0;
          step_cnt_next = '0;
        end
      endcase
    end
  end

  assign leds = leds_reg;
  assign busy = (state_reg != SHOW);

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: constant vector table, hand-written
// corner sequences, and randomized traffic against a position-based model.
module tb_led_sequencer;

  localparam int N  = 4;
  localparam int SC = 3;
  localparam int BB = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          replay = 1'b0;
  logic          loop = 1'b0;
  logic [N-1:0]  pattern = '0;
  logic          pattern_we = 1'b0;
  logic [BB-1:0] brightness = '0;
  logic [N-1:0]  leds;
  logic          busy;

  logic          reset8 = 1'b1;
  logic          z_bit = 1'b0;
  logic [7:0]    z_pat = '0;
  logic [BB-1:0] z_br = '0;
  logic [7:0]    leds8;
  logic          busy8;

  always #5 clock = ~clock;

  led_sequencer #(.N_LEDS(N), .STEP_CYCLES(SC), .BRIGHT_BITS(BB)) dut (
    .clock(clock), .reset(reset), .replay(replay), .loop(loop),
    .pattern(pattern), .pattern_we(pattern_we), .brightness(brightness),
    .leds(leds), .busy(busy)
  );

  led_sequencer #(.N_LEDS(8), .STEP_CYCLES(1), .BRIGHT_BITS(BB)) dut8 (
    .clock(clock), .reset(reset8), .replay(z_bit), .loop(z_bit),
    .pattern(z_pat), .pattern_we(z_bit), .brightness(z_br),
    .leds(leds8), .busy(busy8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ecount = 0;

  // Reference model: animation position derived from clocks since start.
  bit           m_anim;
  int           m_k;
  int           m_e;
  logic [N-1:0] m_leds;
  logic [N-1:0] m_pq;

  // LED image at animation position p (1..2n) for an n-LED bar.
  function automatic logic [7:0] frame(input int n, input int p);
    int v;
    if (p <= n) v = ((1 << p) - 1) << (n - p);
    else        v = (1 << (2 * n - p)) - 1;
    return 8'(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_anim = 1'b1;
    m_k    = 0;
    m_e    = 0;
    m_leds = '0;
    m_pq   = '0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_edge();
    bit           pwm_on;
    logic [N-1:0] pq_old;
    int           p;
    pwm_on = (brightness == '1) || ((m_e % (1 << BB)) < int'(brightness));
    pq_old = m_pq;
    if (replay) begin
      m_anim = 1'b1;
      m_k    = 0;
      m_leds = '0;
    end else if (m_anim) begin
      m_k++;
      if (m_k % SC == 0) begin
        p      = m_k / SC;
        m_leds = N'(frame(N, p));
        if (p == 2 * N) begin
          if (loop) m_k = 0;
          else      m_anim = 1'b0;
        end
      end
    end else begin
      m_leds = pq_old & {N{pwm_on}};
    end
    if (pattern_we) m_pq = pattern;
    m_e++;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    replay     = 1'b0;
    pattern_we = 1'b0;
    ecount++;
    @(negedge clock);
  endtask

  task automatic run_to(input int c);
    while (ecount < c) cycle();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("in_reset leds", 8'(leds), 8'h00);
    check("in_reset busy", 8'(busy), 8'h01);
    reset  = 1'b0;
    ecount = 0;
    model_reset();
  endtask

  typedef struct {
    int           clk;
    logic         rp;
    logic         we;
    logic [N-1:0] pat;
    logic [BB-1:0] br;
    logic         lp;
    logic [N-1:0] exp_leds;
    logic         exp_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Reset release, held pattern, then PWM duty checks in SHOW.
    tbl.push_back('{0,  1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{2,  1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b1});
    tbl.push_back('{3,  1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 4'b1000, 1'b1});
    tbl.push_back('{5,  1'b0, 1'b1, 4'b1010, 2'd3, 1'b0, 4'b1000, 1'b1});
    tbl.push_back('{6,  1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b1100, 1'b1});
    tbl.push_back('{9,  1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b1110, 1'b1});
    tbl.push_back('{12, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b1111, 1'b1});
    tbl.push_back('{15, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b0111, 1'b1});
    tbl.push_back('{18, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b0011, 1'b1});
    tbl.push_back('{21, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b0001, 1'b1});
    tbl.push_back('{23, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b0001, 1'b1});
    tbl.push_back('{24, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{25, 1'b0, 1'b0, 4'b1010, 2'd3, 1'b0, 4'b1010, 1'b0});
    tbl.push_back('{30, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0, 4'b1010, 1'b0});
    tbl.push_back('{31, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{32, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{33, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{34, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{36, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{37, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b1111, 1'b0});
    tbl.push_back('{38, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{41, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0});
    tbl.push_back('{42, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b0});

    brightness = 2'd3;
    do_reset();
    foreach (tbl[i]) begin
      run_to(tbl[i].clk);
      $display("vec clk=%0d leds=%b busy=%b", tbl[i].clk, leds, busy);
      check($sformatf("vec clk%0d leds", tbl[i].clk), 8'(leds), 8'(tbl[i].exp_leds));
      check($sformatf("vec clk%0d busy", tbl[i].clk), 8'(busy), 8'(tbl[i].exp_busy));
      replay     = tbl[i].rp;
      pattern_we = tbl[i].we;
      pattern    = tbl[i].pat;
      brightness = tbl[i].br;
      loop       = tbl[i].lp;
    end

    // Replay mid-fill restarts from empty.
    do_reset();
    run_to(10);
    check("replay pre leds", 8'(leds), 8'(4'b1110));
    replay = 1'b1;
    run_to(11);
    check("replay clk11 leds", 8'(leds), 8'h00);
    check("replay clk11 busy", 8'(busy), 8'h01);
    run_to(13);
    check("replay clk13 leds", 8'(leds), 8'h00);
    run_to(14);
    check("replay clk14 leds", 8'(leds), 8'(4'b1000));
    run_to(34);
    check("replay clk34 leds", 8'(leds), 8'(4'b0001));
    check("replay clk34 busy", 8'(busy), 8'h01);
    run_to(35);
    check("replay clk35 leds", 8'(leds), 8'h00);
    check("replay clk35 busy", 8'(busy), 8'h00);
    $display("seq replay done");

    // Looping animation, then loop cleared mid-run.
    loop = 1'b1;
    do_reset();
    run_to(24);
    check("loop clk24 leds", 8'(leds), 8'h00);
    check("loop clk24 busy", 8'(busy), 8'h01);
    run_to(26);
    check("loop clk26 leds", 8'(leds), 8'h00);
    run_to(27);
    check("loop clk27 leds", 8'(leds), 8'(4'b1000));
    run_to(30);
    loop = 1'b0;
    while (ecount < 47) begin
      cycle();
      check($sformatf("loop clk%0d busy", ecount), 8'(busy), 8'h01);
    end
    check("loop clk47 leds", 8'(leds), 8'(4'b0001));
    run_to(48);
    check("loop clk48 leds", 8'(leds), 8'h00);
    check("loop clk48 busy", 8'(busy), 8'h00);
    $display("seq loop done");

    // Asynchronous reset between edges during DRAIN.
    do_reset();
    run_to(16);
    check("async pre leds", 8'(leds), 8'(4'b0111));
    #2 reset = 1'b1;
    #1;
    check("async leds", 8'(leds), 8'h00);
    check("async busy", 8'(busy), 8'h01);
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b0;
    ecount = 0;
    model_reset();
    run_to(3);
    check("async clk3 leds", 8'(leds), 8'(4'b1000));
    run_to(15);
    check("async clk15 leds", 8'(leds), 8'(4'b0111));
    run_to(24);
    check("async clk24 leds", 8'(leds), 8'h00);
    check("async clk24 busy", 8'(busy), 8'h00);
    $display("seq async reset done");

    // Randomized traffic against the model.
    loop = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 79) == 0) replay = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        pattern_we = 1'b1;
        pattern    = N'($urandom);
      end
      if ($urandom_range(0, 19) == 0) brightness = BB'($urandom);
      if ($urandom_range(0, 99) == 0) loop = ($urandom_range(0, 3) == 0);
      cycle();
      check($sformatf("rand c%0d leds", c), 8'(leds), 8'(m_leds));
      check($sformatf("rand c%0d busy", c), 8'(busy), 8'(m_anim));
    end
    $display("seq random done");

    // 8-LED, single-cycle steps: 16 consecutive shifts.
    @(negedge clock);
    check("n8 reset leds", leds8, 8'h00);
    check("n8 reset busy", 8'(busy8), 8'h01);
    reset8 = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge clock);
      check($sformatf("n8 clk%0d leds", e), leds8, frame(8, e));
      check($sformatf("n8 clk%0d busy", e), 8'(busy8), (e < 16) ? 8'h01 : 8'h00);
    end
    $display("seq n8 done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
